uart_tx: RTL and testbench
==========================

# uart_tx

Byte-oriented UART transmitter with a small write-side FIFO. It is the transmit counterpart of the jacaranda-8 UART receiver. It serialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) onto `tx`, using the same runtime bit-period input `clk_count_bit` as the receiver. The CPU-side MMIO logic pushes bytes via `wr_en`/`wr_data` and watches `full`, `busy` and `end_flag`.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `tx_en` input 1: permits starting new frames. A frame already in progress always completes.
- `wr_en` input 1: push `wr_data` into the FIFO this cycle.
- `wr_data` input 8: byte to enqueue.
- `clk_count_bit` input 32: bit period in clk cycles.
- `tx` output 1: serial line. Registered, idle high.
- `full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `level` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `busy` output 1: FSM not in IDLE.
- `end_flag` output 1: one-cycle pulse at stop-bit completion.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers and an occupancy counter.
  - `full` = (`level` == `FIFO_DEPTH`), derived from registered `level`.
  - `wr_en` while `full` is dropped silently: no pointer or level change. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with FIFO not full: `level` is unchanged, both pointers advance, and the popped byte is the old head.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Bit period**
  - B = `clk_count_bit` latched into an internal register at each frame start (pop).
  - B = 0 is treated as 1.
  - Changes to `clk_count_bit` mid-frame have no effect until the next frame.
- **States** (2-bit): IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If `level`≠0 and `tx_en`: pop the head into the shift register, latch B, clear the bit counter and bit index, drive `tx`=0, go to START.
  - **START:** hold `tx`=0. When counter == B−1: counter←0, `tx`←shift[0], go to DATA.
  - **DATA:** counter increments each cycle. At counter == B−1: counter←0.
    - If bit index < 7: bit index+1 and `tx`←next bit.
    - At bit index 7: `tx`←1 and go to STOP.
  - **STOP:** hold `tx`=1. At counter == B−1, `end_flag`←1 for one cycle, then:
    - if `level`≠0 and `tx_en`: pop and go directly to START with `tx`=0 (no idle gap between frames);
    - else go to IDLE.
- `busy` = (state ≠ IDLE), registered with the state.
- `tx_en` deasserted mid-frame: the frame finishes normally, the FIFO retains its contents, and no new frame starts until `tx_en` returns high.
- **Arithmetic:** 32-bit counter compared against B−1, computed in 32 bits. No overflow is possible since B ≥ 1.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `end_flag`=0, `full`=0, `level`=0, state IDLE. Pointers, counter and bit index are 0.
- **Reset mid-frame:** `tx` returns to 1 on the next edge and FIFO contents are discarded. No `end_flag` is produced.
- **Write latency:** `wr_en` sampled at edge N makes `level`=1 after N.
- **Start latency:** if idle with `tx_en`=1, the pop happens at edge N+1, with `tx`=0 and `busy`=1 after N+1.
- **Frame duration:** exactly 10·B cycles from `tx` falling to the `end_flag` edge.
  - Each bit is held exactly B cycles.
  - `end_flag` is high for the single cycle following the final stop-bit cycle.
- **Back-to-back frames:** the next start bit begins on the same edge that raises `end_flag`. Frame pitch is exactly 10·B.
- `level` decrements on the pop edge.
  - `full` deasserts on the cycle after a pop from a full FIFO.
  - A write in that pop cycle is still rejected.

## Test plan
- **Single frame:** B=4, `tx_en`=1, write 0xA5. Expect `tx` = 0, then 1,0,1,0,0,1,0,1, then stop 1, each level held 4 cycles. `end_flag` pulses once, 40 cycles after `tx` falls, and `busy` drops on that same edge.
- **FIFO overflow, DEPTH=4:** `tx_en`=0, write 0x01..0x05 on consecutive cycles. Expect `level`=4 and `full`=1, with 0x05 dropped. Then raise `tx_en`: expect four contiguous frames 0x01..0x04 at a 40-cycle pitch (B=4), four `end_flag` pulses, and `level` finishing at 0.
- **Simultaneous push/pop:** with 2 entries queued, push 0x3C on the exact cycle a frame pops. Expect `level` to stay at 2 and 0x3C to be transmitted last.
- **B change and B=0:** set `clk_count_bit`=8, write 0xFF, then change to 2 mid-frame. Expect the whole frame at 8 cycles per bit and the next frame at 2 cycles per bit. With `clk_count_bit`=0, write 0x00: expect a 10-cycle frame.
- **`tx_en` drop:** queue 2 bytes and deassert `tx_en` during frame 1 DATA. Expect frame 1 to complete, `tx` to stay 1, and `level`=1. Reassert `tx_en`: frame 2 starts on the next cycle.
- **Reset mid-frame:** assert `reset` during DATA with 3 bytes queued. Expect `tx`=1, `level`=0, `busy`=0, and `end_flag`=0 after the edge. No further frames are sent.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write-side FIFO.
// The bit period is taken from clk_count_bit when each frame starts, and
// consecutive queued bytes are sent with no idle gap between frames.
module uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic [31:0]                   clk_count_bit,
  output logic                          tx,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          end_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  // Transmit datapath and control
  state_t        r_state;
  logic          r_tx;
  logic          r_end_flag;
  logic [31:0]   r_cnt;
  logic [2:0]    r_bidx;
  logic [7:0]    r_shift;
  logic [31:0]   r_bper;

  // Next-state values produced by the FSM
  state_t        w_nstate;
  logic          w_ntx;
  logic          w_nend;
  logic [31:0]   w_ncnt;
  logic [2:0]    w_nbidx;
  logic [7:0]    w_nshift;
  logic [31:0]   w_nbper;
  logic          w_pop;

  logic          w_full;
  logic          w_push;
  logic          w_can_pop;
  logic [7:0]    w_head;
  logic [31:0]   w_bsel;
  logic [31:0]   w_bm1;
  logic          w_bit_done;

  // A write into a full FIFO is dropped even when a pop frees a slot that
  // same cycle; full is based on the registered occupancy only.
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_push     = wr_en && !w_full;
  assign w_can_pop  = (r_level != '0) && tx_en;
  assign w_head     = r_mem[r_rptr];
  // A zero bit period would never terminate a bit; run it as one cycle.
  assign w_bsel     = (clk_count_bit == 32'd0) ? 32'd1 : clk_count_bit;
  assign w_bm1      = r_bper - 32'd1;
  assign w_bit_done = (r_cnt == w_bm1);

  assign tx       = r_tx;
  assign full     = w_full;
  assign level    = r_level;
  assign busy     = (r_state != S_IDLE);
  assign end_flag = r_end_flag;

  // FIFO data array: written on accepted pushes, not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // FSM state register together with the serial datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_end_flag <= 1'b0;
      r_cnt      <= '0;
      r_bidx     <= '0;
      r_shift    <= '0;
      r_bper     <= 32'd1;
    end else begin
      r_state    <= w_nstate;
      r_tx       <= w_ntx;
      r_end_flag <= w_nend;
      r_cnt      <= w_ncnt;
      r_bidx     <= w_nbidx;
      r_shift    <= w_nshift;
      r_bper     <= w_nbper;
    end
  end

  // FSM next-state logic: frame sequencing, bit timing and FIFO pop
  always_comb begin
    w_nstate = r_state;
    w_ntx    = r_tx;
    w_nend   = 1'b0;
    w_ncnt   = r_cnt;
    w_nbidx  = r_bidx;
    w_nshift = r_shift;
    w_nbper  = r_bper;
    w_pop    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ntx = 1'b1;
        if (w_can_pop) begin
          w_pop    = 1'b1;
          w_nshift = w_head;
          w_nbper  = w_bsel;
          w_ncnt   = '0;
          w_nbidx  = '0;
          w_ntx    = 1'b0;
          w_nstate = S_START;
        end
      end

      S_START: begin
        w_ntx = 1'b0;
        if (w_bit_done) begin
          w_ncnt   = '0;
          w_ntx    = r_shift[0];
          w_nshift = {1'b0, r_shift[7:1]};
          w_nstate = S_DATA;
        end else begin
          w_ncnt = r_cnt + 32'd1;
        end
      end

      S_DATA: begin
        if (w_bit_done) begin
          w_ncnt = '0;
          if (r_bidx != 3'd7) begin
            w_nbidx  = r_bidx + 3'd1;
            w_ntx    = r_shift[0];
            w_nshift = {1'b0, r_shift[7:1]};
          end else begin
            w_ntx    = 1'b1;
            w_nstate = S_STOP;
          end
        end else begin
          w_ncnt = r_cnt + 32'd1;
        end
      end

      S_STOP: begin
        w_ntx = 1'b1;
        if (w_bit_done) begin
          w_nend = 1'b1;
          w_ncnt = '0;
          // Chain straight into the next start bit when more data is queued.
          if (w_can_pop) begin
            w_pop    = 1'b1;
            w_nshift = w_head;
            w_nbper  = w_bsel;
            w_nbidx  = '0;
            w_ntx    = 1'b0;
            w_nstate = S_START;
          end else begin
            w_nstate = S_IDLE;
          end
        end else begin
          w_ncnt = r_cnt + 32'd1;
        end
      end

      default: begin
        w_nstate = S_IDLE;
        w_ntx    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard testbench for uart_tx: stimulus queues expected frames, a
// monitor decodes the serial line and checks each frame against the queue.
module tb_uart_tx;

  logic        clk;
  logic        reset;
  logic        tx_en;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [31:0] clk_count_bit;
  logic        tx;
  logic        full;
  logic [2:0]  level;
  logic        busy;
  logic        end_flag;

  uart_tx #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_en         (tx_en),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .clk_count_bit (clk_count_bit),
    .tx            (tx),
    .full          (full),
    .level         (level),
    .busy          (busy),
    .end_flag      (end_flag)
  );

  typedef struct {
    logic [7:0] data;
    int         b;
    logic       b2b;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en   = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input int b, input logic b2b);
    exp_t e;
    e.data = d;
    e.b    = b;
    e.b2b  = b2b;
    q.push_back(e);
  endtask

  task automatic wait_ends(input int n, input int budget, input string name);
    int got = 0;
    int c   = 0;
    while (got < n && c < budget) begin
      tick();
      c++;
      if (end_flag === 1'b1) got++;
    end
    check(name, got, n);
  endtask

  // Checks one frame that started (tx fell) at the current negedge sample.
  task automatic run_frame(input exp_t e);
    int         bad = 0;
    logic [9:0] fr;
    logic [7:0] got = 8'h00;
    fr = {1'b1, e.data, 1'b0};
    for (int k = 0; k < 10 * e.b; k++) begin
      if (k > 0) @(negedge clk);
      if (tx !== fr[k / e.b]) bad++;
      if (busy !== 1'b1) bad++;
      if (end_flag !== ((k == 0) ? e.b2b : 1'b0)) bad++;
      if ((k / e.b) >= 1 && (k / e.b) <= 8 && (k % e.b) == (e.b / 2))
        got[(k / e.b) - 1] = tx;
    end
    @(negedge clk);
    check("frame_data", got, e.data);
    check("frame_shape", bad, 0);
    check("frame_end_flag", end_flag, 1'b1);
  endtask

  // Monitor: detect start bits on tx and compare each frame with the queue
  initial begin : monitor
    logic prev_tx;
    exp_t e;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      while (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
        if (q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          prev_tx = 1'b0;
        end else begin
          e = q.pop_front();
          run_frame(e);
          prev_tx = 1'b1;
        end
      end
      prev_tx = tx;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int bad;
    reset         = 1'b1;
    tx_en         = 1'b0;
    wr_en         = 1'b0;
    wr_data       = 8'h00;
    clk_count_bit = 32'd4;
    repeat (3) tick();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_end_flag", end_flag, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 3'd0);
    reset = 1'b0;
    tick();

    // Single frame, B=4
    tx_en = 1'b1;
    push_exp(8'hA5, 4, 1'b0);
    write_byte(8'hA5);
    check("t1_level_after_write", level, 3'd1);
    wait_ends(1, 100, "t1_end");
    check("t1_busy_at_end", busy, 1'b0);
    check("t1_tx_at_end", tx, 1'b1);
    check("t1_level_at_end", level, 3'd0);
    repeat (3) tick();

    // FIFO overflow with tx_en low
    tx_en = 1'b0;
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    check("t2_level_full", level, 3'd4);
    check("t2_full", full, 1'b1);
    push_exp(8'h01, 4, 1'b0);
    push_exp(8'h02, 4, 1'b1);
    push_exp(8'h03, 4, 1'b1);
    push_exp(8'h04, 4, 1'b1);
    // Pop from full FIFO with a write in the same cycle: write is rejected.
    tx_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h06;
    tick();
    wr_en = 1'b0;
    check("t2_level_after_pop", level, 3'd3);
    check("t2_full_after_pop", full, 1'b0);
    wait_ends(4, 400, "t2_four_ends");
    check("t2_level_final", level, 3'd0);
    repeat (3) tick();

    // Simultaneous push and pop
    tx_en = 1'b0;
    write_byte(8'h11);
    write_byte(8'h22);
    check("t3_level_two", level, 3'd2);
    push_exp(8'h11, 4, 1'b0);
    push_exp(8'h22, 4, 1'b1);
    push_exp(8'h3C, 4, 1'b1);
    tx_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    check("t3_level_push_pop", level, 3'd2);
    check("t3_busy", busy, 1'b1);
    wait_ends(3, 400, "t3_three_ends");
    check("t3_level_final", level, 3'd0);
    repeat (3) tick();

    // Bit-period change mid-frame, then B=0
    clk_count_bit = 32'd8;
    push_exp(8'hFF, 8, 1'b0);
    write_byte(8'hFF);
    repeat (20) tick();
    clk_count_bit = 32'd2;
    push_exp(8'h5A, 2, 1'b1);
    write_byte(8'h5A);
    wait_ends(2, 300, "t4_two_ends");
    repeat (3) tick();
    clk_count_bit = 32'd0;
    push_exp(8'h00, 1, 1'b0);
    write_byte(8'h00);
    wait_ends(1, 50, "t4_b0_end");
    repeat (3) tick();

    // tx_en dropped during a frame
    clk_count_bit = 32'd4;
    tx_en = 1'b0;
    write_byte(8'h81);
    write_byte(8'h42);
    push_exp(8'h81, 4, 1'b0);
    tx_en = 1'b1;
    tick();
    repeat (14) tick();
    tx_en = 1'b0;
    wait_ends(1, 100, "t5_frame1_end");
    repeat (5) tick();
    check("t5_tx_idle", tx, 1'b1);
    check("t5_level_kept", level, 3'd1);
    check("t5_busy_idle", busy, 1'b0);
    push_exp(8'h42, 4, 1'b0);
    tx_en = 1'b1;
    tick();
    check("t5_restart_busy", busy, 1'b1);
    check("t5_restart_tx", tx, 1'b0);
    wait_ends(1, 100, "t5_frame2_end");
    repeat (3) tick();

    // Reset mid-frame with bytes queued
    mon_en = 1'b0;
    tx_en  = 1'b1;
    write_byte(8'h10);
    write_byte(8'h20);
    write_byte(8'h30);
    repeat (10) tick();
    check("t6_in_frame", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("t6_rst_tx", tx, 1'b1);
    check("t6_rst_level", level, 3'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_end_flag", end_flag, 1'b0);
    check("t6_rst_full", full, 1'b0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || end_flag !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t6_quiet_after_reset", bad, 0);
    check("t6_level_after", level, 3'd0);

    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
